cpu_control: RTL and testbench

Multi-cycle control FSM for the 16-bit CPU. It sequences the datapath one step per cycle: fetch, PC increment, decode, then the per-instruction micro-steps, each driven as a single strobe. It consumes the datapath's opcode and N/Z flags, and drives the datapath strobe inputs plus the memory read/write enables. Memory wait states are supported through a stall input.

---
 rtl/cpu_pkg.sv | 154 +++++++++++++++
 rtl/cpu_opdecode.sv | 50 +++++
 rtl/cpu_control.sv | 191 +++++++++++++++++++
 tb/tb_cpu_control.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the 16-bit CPU control path.
//   opcode_t  - 5-bit instruction opcodes as seen on the datapath o_opCode.
//   state_t   - control FSM states (fetch/decode plus per-instruction steps).
//   iclass_t  - instruction class produced by cpu_opdecode.
//   cond_t    - flag selected by a conditional jump.
//   ctrl_t    - bundle of every control output driven by cpu_control.
//   ctrl_for  - Moore output decode: the control bundle for a given state.
package cpu_pkg;

  typedef enum logic [4:0] {
    OP_MV    = 5'b00000,
    OP_ADD   = 5'b00001,
    OP_SUB   = 5'b00010,
    OP_CMP   = 5'b00011,
    OP_LD    = 5'b00100,
    OP_ST    = 5'b00101,
    OP_JR    = 5'b01000,
    OP_JZR   = 5'b01001,
    OP_JNR   = 5'b01010,
    OP_CALLR = 5'b01100,
    OP_MVI   = 5'b10000,
    OP_ADDI  = 5'b10001,
    OP_SUBI  = 5'b10010,
    OP_CMPI  = 5'b10011,
    OP_MVHI  = 5'b10110,
    OP_J     = 5'b11000,
    OP_JZ    = 5'b11001,
    OP_JN    = 5'b11010,
    OP_CALL  = 5'b11100
  } opcode_t;

  typedef enum logic [4:0] {
    S_RESET,
    S_FETCH_ADDR,
    S_FETCH_WAIT,
    S_FETCH_IR,
    S_INC_PC,
    S_UPD_PC,
    S_DECODE,
    S_MV_RD,
    S_MV_WR,
    S_ALU_RX,
    S_ALU_RY,
    S_ALU_IMM,
    S_ALU_ADD,
    S_ALU_WB,
    S_LD_RD,
    S_LD_MEM,
    S_LD_WAIT,
    S_LD_WB,
    S_ST_RX,
    S_ST_RY,
    S_ST_WR,
    S_MVHI_RD,
    S_MVI,
    S_JUMP,
    S_CALL,
    S_NEW_PC,
    S_ILLEGAL
  } state_t;

  typedef enum logic [3:0] {
    CL_MV,
    CL_ALU,
    CL_ALUI,
    CL_LD,
    CL_ST,
    CL_MVI,
    CL_MVHI,
    CL_JMP,
    CL_JCOND,
    CL_CALL,
    CL_BAD
  } iclass_t;

  typedef enum logic {
    COND_Z,
    COND_N
  } cond_t;

  typedef struct packed {
    logic dp_reset;
    logic set_addr;
    logic read_data;
    logic inc_PC;
    logic updatePC;
    logic read_IR;
    logic mv_rd;
    logic mv_wr;
    logic readRx_add;
    logic readRy_add;
    logic add_add;
    logic writeRx_add;
    logic ld_rd;
    logic readMem;
    logic writeRx_ld;
    logic st_Rx;
    logic rd_Rx_mvi;
    logic mvi;
    logic addi;
    logic jump;
    logic new_PC;
    logic call;
    logic mem_rd;
    logic mem_wr;
    logic illegal;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_RESET:      c.dp_reset = 1'b1;
      S_FETCH_ADDR: begin
        c.set_addr = 1'b1;
        c.mem_rd   = 1'b1;
      end
      S_FETCH_WAIT: c.mem_rd = 1'b1;
      S_FETCH_IR:   c.read_data = 1'b1;
      S_INC_PC:     c.inc_PC = 1'b1;
      S_UPD_PC:     c.updatePC = 1'b1;
      S_DECODE:     c.read_IR = 1'b1;
      S_MV_RD:      c.mv_rd = 1'b1;
      S_MV_WR:      c.mv_wr = 1'b1;
      S_ALU_RX,
      S_ST_RX:      c.readRx_add = 1'b1;
      S_ALU_RY,
      S_ST_RY:      c.readRy_add = 1'b1;
      S_ALU_IMM:    c.addi = 1'b1;
      S_ALU_ADD:    c.add_add = 1'b1;
      S_ALU_WB:     c.writeRx_add = 1'b1;
      S_LD_RD:      c.ld_rd = 1'b1;
      S_LD_MEM:     begin
        c.readMem = 1'b1;
        c.mem_rd  = 1'b1;
      end
      S_LD_WAIT:    c.mem_rd = 1'b1;
      S_LD_WB:      c.writeRx_ld = 1'b1;
      S_ST_WR:      begin
        c.st_Rx  = 1'b1;
        c.mem_wr = 1'b1;
      end
      S_MVHI_RD:    c.rd_Rx_mvi = 1'b1;
      S_MVI:        c.mvi = 1'b1;
      S_JUMP:       c.jump = 1'b1;
      S_CALL:       c.call = 1'b1;
      S_NEW_PC:     c.new_PC = 1'b1;
      S_ILLEGAL:    c.illegal = 1'b1;
      default:      c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_opdecode.sv
// cpu_opdecode: combinational opcode classifier for the control FSM.
// Ports:
//   i_opcode   in  5  datapath opcode
//   o_class    out    instruction class (CL_BAD for undefined opcodes)
//   o_is_cmp   out 1  compare form: ALU sequence without the register write-back
//   o_cond_sel out    flag tested by a conditional jump (Z or N)
module cpu_opdecode
  import cpu_pkg::*;
(
  input  logic [4:0] i_opcode,
  output iclass_t    o_class,
  output logic       o_is_cmp,
  output cond_t      o_cond_sel
);

  always_comb begin
    o_class    = CL_BAD;
    o_is_cmp   = 1'b0;
    o_cond_sel = COND_Z;
    case (i_opcode)
      OP_MV:            o_class = CL_MV;
      OP_ADD, OP_SUB:   o_class = CL_ALU;
      OP_CMP:           begin
        o_class  = CL_ALU;
        o_is_cmp = 1'b1;
      end
      OP_ADDI, OP_SUBI: o_class = CL_ALUI;
      OP_CMPI:          begin
        o_class  = CL_ALUI;
        o_is_cmp = 1'b1;
      end
      OP_LD:            o_class = CL_LD;
      OP_ST:            o_class = CL_ST;
      OP_MVI:           o_class = CL_MVI;
      OP_MVHI:          o_class = CL_MVHI;
      OP_JR, OP_J:      o_class = CL_JMP;
      OP_JZR, OP_JZ:    begin
        o_class    = CL_JCOND;
        o_cond_sel = COND_Z;
      end
      OP_JNR, OP_JN:    begin
        o_class    = CL_JCOND;
        o_cond_sel = COND_N;
      end
      OP_CALLR, OP_CALL: o_class = CL_CALL;
      default:          o_class = CL_BAD;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// cpu_control: multi-cycle control FSM for the 16-bit CPU.
// Sequences fetch, PC increment, decode and the per-instruction micro-steps,
// driving one datapath strobe per cycle plus the memory enables.
// Ports:
//   clk, i_reset (sync, active-high), i_opcode[4:0], i_N, i_Z, i_mem_wait
//   o_* datapath strobes, o_mem_rd, o_mem_wr, o_illegal (one-cycle pulse)
// Optional build macro CPU_CTRL_PERF_EN adds o_instr_count[31:0] (DECODE exits)
// and o_stall_count[31:0] (cycles held by i_mem_wait), both wrapping.
module cpu_control
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       i_reset,
  input  logic [4:0] i_opcode,
  input  logic       i_N,
  input  logic       i_Z,
  input  logic       i_mem_wait,
  output logic       o_dp_reset,
  output logic       o_set_addr,
  output logic       o_read_data,
  output logic       o_inc_PC,
  output logic       o_updatePC,
  output logic       o_read_IR,
  output logic       o_mv_rd,
  output logic       o_mv_wr,
  output logic       o_readRx_add,
  output logic       o_readRy_add,
  output logic       o_add_add,
  output logic       o_writeRx_add,
  output logic       o_ld_rd,
  output logic       o_readMem,
  output logic       o_writeRx_ld,
  output logic       o_st_Rx,
  output logic       o_rd_Rx_mvi,
  output logic       o_mvi,
  output logic       o_addi,
  output logic       o_jump,
  output logic       o_new_PC,
  output logic       o_call,
  output logic       o_mem_rd,
  output logic       o_mem_wr,
  output logic       o_illegal
`ifdef CPU_CTRL_PERF_EN
  ,
  output logic [31:0] o_instr_count,
  output logic [31:0] o_stall_count
`endif
);

  state_t  r_state;
  state_t  w_next;
  ctrl_t   r_ctrl;
  iclass_t w_class;
  iclass_t r_class;
  logic    w_is_cmp;
  logic    r_is_cmp;
  cond_t   w_cond_sel;
  cond_t   r_cond_sel;
  logic    w_taken;

  cpu_opdecode u_opdecode (
    .i_opcode   (i_opcode),
    .o_class    (w_class),
    .o_is_cmp   (w_is_cmp),
    .o_cond_sel (w_cond_sel)
  );

  assign w_taken = (r_cond_sel == COND_N) ? i_N : i_Z;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:      w_next = S_FETCH_ADDR;
      S_FETCH_ADDR: w_next = S_FETCH_WAIT;
      S_FETCH_WAIT: w_next = i_mem_wait ? S_FETCH_WAIT : S_FETCH_IR;
      S_FETCH_IR:   w_next = S_INC_PC;
      S_INC_PC:     w_next = S_UPD_PC;
      S_UPD_PC:     w_next = S_DECODE;
      S_DECODE: begin
        case (w_class)
          CL_MV:              w_next = S_MV_RD;
          CL_ALU, CL_ALUI:    w_next = S_ALU_RX;
          CL_LD:              w_next = S_LD_RD;
          CL_ST:              w_next = S_ST_RX;
          CL_MVI:             w_next = S_MVI;
          CL_MVHI:            w_next = S_MVHI_RD;
          CL_JMP, CL_JCOND,
          CL_CALL:            w_next = S_JUMP;
          default:            w_next = S_ILLEGAL;
        endcase
      end
      S_MV_RD:      w_next = S_MV_WR;
      S_MV_WR:      w_next = S_FETCH_ADDR;
      S_ALU_RX:     w_next = (r_class == CL_ALUI) ? S_ALU_IMM : S_ALU_RY;
      S_ALU_RY,
      S_ALU_IMM:    w_next = S_ALU_ADD;
      S_ALU_ADD:    w_next = r_is_cmp ? S_FETCH_ADDR : S_ALU_WB;
      S_ALU_WB:     w_next = S_FETCH_ADDR;
      S_LD_RD:      w_next = S_LD_MEM;
      S_LD_MEM:     w_next = S_LD_WAIT;
      S_LD_WAIT:    w_next = i_mem_wait ? S_LD_WAIT : S_LD_WB;
      S_LD_WB:      w_next = S_FETCH_ADDR;
      S_ST_RX:      w_next = S_ST_RY;
      S_ST_RY:      w_next = S_ST_WR;
      S_ST_WR:      w_next = S_FETCH_ADDR;
      S_MVHI_RD:    w_next = S_MVI;
      S_MVI:        w_next = S_FETCH_ADDR;
      S_JUMP: begin
        case (r_class)
          CL_JMP:  w_next = S_NEW_PC;
          CL_CALL: w_next = S_CALL;
          default: w_next = w_taken ? S_NEW_PC : S_FETCH_ADDR;
        endcase
      end
      S_CALL:       w_next = S_NEW_PC;
      S_NEW_PC:     w_next = S_FETCH_ADDR;
      S_ILLEGAL:    w_next = S_FETCH_ADDR;
      default:      w_next = S_RESET;
    endcase
  end

  // Outputs are registered alongside the state from the next-state decode,
  // so r_ctrl always equals ctrl_for(r_state) without a combinational path.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state    <= S_RESET;
      r_ctrl     <= ctrl_for(S_RESET);
      r_class    <= CL_BAD;
      r_is_cmp   <= 1'b0;
      r_cond_sel <= COND_Z;
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_for(w_next);
      // The opcode is only guaranteed during DECODE; keep its class for the steps after.
      if (r_state == S_DECODE) begin
        r_class    <= w_class;
        r_is_cmp   <= w_is_cmp;
        r_cond_sel <= w_cond_sel;
      end
    end
  end

  assign o_dp_reset    = r_ctrl.dp_reset;
  assign o_set_addr    = r_ctrl.set_addr;
  assign o_read_data   = r_ctrl.read_data;
  assign o_inc_PC      = r_ctrl.inc_PC;
  assign o_updatePC    = r_ctrl.updatePC;
  assign o_read_IR     = r_ctrl.read_IR;
  assign o_mv_rd       = r_ctrl.mv_rd;
  assign o_mv_wr       = r_ctrl.mv_wr;
  assign o_readRx_add  = r_ctrl.readRx_add;
  assign o_readRy_add  = r_ctrl.readRy_add;
  assign o_add_add     = r_ctrl.add_add;
  assign o_writeRx_add = r_ctrl.writeRx_add;
  assign o_ld_rd       = r_ctrl.ld_rd;
  assign o_readMem     = r_ctrl.readMem;
  assign o_writeRx_ld  = r_ctrl.writeRx_ld;
  assign o_st_Rx       = r_ctrl.st_Rx;
  assign o_rd_Rx_mvi   = r_ctrl.rd_Rx_mvi;
  assign o_mvi         = r_ctrl.mvi;
  assign o_addi        = r_ctrl.addi;
  assign o_jump        = r_ctrl.jump;
  assign o_new_PC      = r_ctrl.new_PC;
  assign o_call        = r_ctrl.call;
  assign o_mem_rd      = r_ctrl.mem_rd;
  assign o_mem_wr      = r_ctrl.mem_wr;
  assign o_illegal     = r_ctrl.illegal;

`ifdef CPU_CTRL_PERF_EN
  logic [31:0] r_instr_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_instr_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (r_state == S_DECODE) begin
        r_instr_count <= r_instr_count + 32'd1;
      end
      if (((r_state == S_FETCH_WAIT) || (r_state == S_LD_WAIT)) && i_mem_wait) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign o_instr_count = r_instr_count;
  assign o_stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: self-checking bench for cpu_control.
// A per-instruction model expands each opcode into its expected cycle-by-cycle
// output trace (including wait cycles); every cycle the DUT outputs are
// compared against that trace. Directed cases pin cycle counts by literal.
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [4:0] i_opcode = '0;
  logic       i_N = 1'b0;
  logic       i_Z = 1'b0;
  logic       i_mem_wait = 1'b0;
  logic o_dp_reset, o_set_addr, o_read_data, o_inc_PC, o_updatePC, o_read_IR;
  logic o_mv_rd, o_mv_wr, o_readRx_add, o_readRy_add, o_add_add, o_writeRx_add;
  logic o_ld_rd, o_readMem, o_writeRx_ld, o_st_Rx, o_rd_Rx_mvi, o_mvi, o_addi;
  logic o_jump, o_new_PC, o_call, o_mem_rd, o_mem_wr, o_illegal;
`ifdef CPU_CTRL_PERF_EN
  logic [31:0] o_instr_count, o_stall_count;
`endif

  always #5 clk = ~clk;

  cpu_control dut (
    .clk(clk), .i_reset(i_reset), .i_opcode(i_opcode), .i_N(i_N), .i_Z(i_Z),
    .i_mem_wait(i_mem_wait),
    .o_dp_reset(o_dp_reset), .o_set_addr(o_set_addr), .o_read_data(o_read_data),
    .o_inc_PC(o_inc_PC), .o_updatePC(o_updatePC), .o_read_IR(o_read_IR),
    .o_mv_rd(o_mv_rd), .o_mv_wr(o_mv_wr), .o_readRx_add(o_readRx_add),
    .o_readRy_add(o_readRy_add), .o_add_add(o_add_add), .o_writeRx_add(o_writeRx_add),
    .o_ld_rd(o_ld_rd), .o_readMem(o_readMem), .o_writeRx_ld(o_writeRx_ld),
    .o_st_Rx(o_st_Rx), .o_rd_Rx_mvi(o_rd_Rx_mvi), .o_mvi(o_mvi), .o_addi(o_addi),
    .o_jump(o_jump), .o_new_PC(o_new_PC), .o_call(o_call),
    .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_illegal(o_illegal)
`ifdef CPU_CTRL_PERF_EN
    , .o_instr_count(o_instr_count), .o_stall_count(o_stall_count)
`endif
  );

  // Output vector bit positions
  localparam int DPR = 0, SETA = 1, RDAT = 2, INCP = 3, UPDP = 4, RIR = 5;
  localparam int MVRD = 6, MVWR = 7, RX = 8, RY = 9, ADD = 10, WRX = 11;
  localparam int LDRD = 12, RMEM = 13, WRXLD = 14, STRX = 15, RDMVI = 16;
  localparam int MVI = 17, ADDI = 18, JMP = 19, NPC = 20, CALL = 21;
  localparam int MRD = 22, MWR = 23, ILL = 24;

  logic [24:0] act;
  assign act = {o_illegal, o_mem_wr, o_mem_rd, o_call, o_new_PC, o_jump, o_addi,
                o_mvi, o_rd_Rx_mvi, o_st_Rx, o_writeRx_ld, o_readMem, o_ld_rd,
                o_writeRx_add, o_add_add, o_readRy_add, o_readRx_add, o_mv_wr,
                o_mv_rd, o_read_IR, o_updatePC, o_inc_PC, o_read_data, o_set_addr,
                o_dp_reset};

  int unsigned total = 0;
  int unsigned bad = 0;

  typedef struct {
    logic [24:0] v;
    bit care;   // i_mem_wait is meaningful in this cycle
    bit w;      // value to drive when meaningful
    bit dec;    // the DECODE cycle
  } ent_t;
  ent_t q[$];

  int unsigned m_instr = 0;
  int unsigned m_stall = 0;
  int hist[25];

  logic [4:0] valid_ops[19] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h08,
                                5'h09, 5'h0A, 5'h0C, 5'h10, 5'h11, 5'h12, 5'h13,
                                5'h16, 5'h18, 5'h19, 5'h1A, 5'h1C};

  function automatic logic [24:0] B(input int i);
    return 25'(1) << i;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic push(input logic [24:0] v, input bit care = 1'b0, input bit w = 1'b0,
                      input bit dec = 1'b0);
    ent_t e;
    e.v = v; e.care = care; e.w = w; e.dec = dec;
    q.push_back(e);
  endtask

  // Expected trace of one instruction from FETCH_ADDR up to its last step.
  task automatic build(input logic [4:0] op, input bit n, input bit z,
                       input int fw, input int lw);
    q.delete();
    push(B(SETA) | B(MRD));
    for (int k = 0; k < fw; k++) push(B(MRD), 1'b1, 1'b1);
    push(B(MRD), 1'b1, 1'b0);
    push(B(RDAT));
    push(B(INCP));
    push(B(UPDP));
    push(B(RIR), 1'b0, 1'b0, 1'b1);
    case (op)
      5'h00: begin push(B(MVRD)); push(B(MVWR)); end
      5'h01, 5'h02: begin push(B(RX)); push(B(RY)); push(B(ADD)); push(B(WRX)); end
      5'h03: begin push(B(RX)); push(B(RY)); push(B(ADD)); end
      5'h11, 5'h12: begin push(B(RX)); push(B(ADDI)); push(B(ADD)); push(B(WRX)); end
      5'h13: begin push(B(RX)); push(B(ADDI)); push(B(ADD)); end
      5'h04: begin
        push(B(LDRD));
        push(B(RMEM) | B(MRD));
        for (int k = 0; k < lw; k++) push(B(MRD), 1'b1, 1'b1);
        push(B(MRD), 1'b1, 1'b0);
        push(B(WRXLD));
      end
      5'h05: begin push(B(RX)); push(B(RY)); push(B(STRX) | B(MWR)); end
      5'h10: push(B(MVI));
      5'h16: begin push(B(RDMVI)); push(B(MVI)); end
      5'h08, 5'h18: begin push(B(JMP)); push(B(NPC)); end
      5'h09, 5'h19: begin push(B(JMP)); if (z) push(B(NPC)); end
      5'h0A, 5'h1A: begin push(B(JMP)); if (n) push(B(NPC)); end
      5'h0C, 5'h1C: begin push(B(JMP)); push(B(CALL)); push(B(NPC)); end
      default: push(B(ILL));
    endcase
  endtask

  task automatic chk_perf(input string nm);
`ifdef CPU_CTRL_PERF_EN
    chk({nm, "_instr_count"}, o_instr_count, m_instr);
    chk({nm, "_stall_count"}, o_stall_count, m_stall);
`else
    if (nm.len() < 0) $display("unused %s", nm);
`endif
  endtask

  task automatic do_reset(input int n);
    i_reset = 1'b1;
    i_mem_wait = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      chk("reset_outputs", 32'(act), 32'(B(DPR)));
    end
    m_instr = 0; m_stall = 0;
    chk_perf("reset");
    i_reset = 1'b0;
    i_mem_wait = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drive one instruction from FETCH_ADDR, checking every cycle against the model.
  // abort_at >= 0 asserts i_reset during that trace index.
  task automatic run_instr(input logic [4:0] op, input bit n, input bit z,
                           input int fw, input int lw, input int abort_at);
    bit seen_dec;
    build(op, n, z, fw, lw);
    i_N = n; i_Z = z;
    seen_dec = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].dec) seen_dec = 1'b1;
      i_opcode = seen_dec ? op : 5'($urandom);
      chk($sformatf("op%02h_step%0d", op, i), 32'(act), 32'(q[i].v));
      chk_perf($sformatf("op%02h_step%0d", op, i));
      if (i == abort_at) begin
        i_reset = 1'b1;
        i_mem_wait = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("op%02h_abort%0d", op, i), 32'(act), 32'(B(DPR)));
        m_instr = 0; m_stall = 0;
        chk_perf("abort");
        i_reset = 1'b0;
        i_mem_wait = 1'b0;
        @(posedge clk); #1;
        return;
      end
      i_mem_wait = q[i].care ? q[i].w : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (q[i].dec) m_instr++;
      if (q[i].care && q[i].w) m_stall++;
    end
  endtask

  // Runs an instruction observing only the DUT: counts cycles until the next
  // FETCH_ADDR and tallies each output, inserting fw/lw memory waits.
  task automatic measure(input logic [4:0] op, input bit n, input bit z,
                         input int fw, input int lw, output int cyc);
    int fwl, lwl;
    bit in_ld;
    fwl = fw; lwl = lw; in_ld = 1'b0; cyc = 0;
    foreach (hist[k]) hist[k] = 0;
    i_opcode = op; i_N = n; i_Z = z;
    do begin
      foreach (hist[k]) hist[k] += int'(act[k]);
      if (act[RMEM]) in_ld = 1'b1;
      i_mem_wait = 1'b0;
      if (act == B(MRD)) begin
        if (!in_ld && fwl > 0) begin i_mem_wait = 1'b1; fwl--; end
        if (in_ld && lwl > 0) begin i_mem_wait = 1'b1; lwl--; end
      end
      @(posedge clk); #1;
      cyc++;
    end while (!act[SETA] && cyc < 40);
    i_mem_wait = 1'b0;
    if (!act[SETA]) begin
      chk($sformatf("op%02h_timeout", op), 32'(cyc), 32'd0);
      do_reset(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset held 3 cycles, then first fetch cycle
    do_reset(3);
    chk("after_reset_fetch", 32'(act), 32'(B(SETA) | B(MRD)));

    measure(5'h00, 0, 0, 0, 0, cyc);  chk("mv_cycles", cyc, 8);
    chk("mv_wr_count", hist[MVWR], 1);

    do_reset(1);
    measure(5'h04, 0, 0, 2, 3, cyc);  chk("ld_wait_cycles", cyc, 15);
    chk("ld_writeRx_ld_count", hist[WRXLD], 1);
`ifdef CPU_CTRL_PERF_EN
    chk("ld_stall_count", o_stall_count, 5);
    chk("ld_instr_count", o_instr_count, 1);
`endif

    measure(5'h03, 0, 0, 0, 0, cyc);  chk("cmp_cycles", cyc, 9);
    chk("cmp_no_writeRx_add", hist[WRX], 0);
    measure(5'h09, 0, 1, 0, 0, cyc);  chk("jz_taken_cycles", cyc, 8);
    chk("jz_taken_new_PC", hist[NPC], 1);
    measure(5'h03, 0, 0, 0, 0, cyc);  chk("cmp2_cycles", cyc, 9);
    measure(5'h09, 1, 0, 0, 0, cyc);  chk("jz_not_taken_cycles", cyc, 7);
    chk("jz_not_taken_new_PC", hist[NPC], 0);
    measure(5'h1C, 0, 0, 0, 0, cyc);  chk("call_cycles", cyc, 9);
    chk("call_call_count", hist[CALL], 1);
    measure(5'h07, 0, 0, 0, 0, cyc);  chk("illegal_cycles", cyc, 7);
    chk("illegal_pulse_count", hist[ILL], 1);
    measure(5'h10, 0, 0, 0, 0, cyc);  chk("mvi_cycles", cyc, 7);
    measure(5'h11, 0, 0, 0, 0, cyc);  chk("addi_cycles", cyc, 10);
    measure(5'h05, 0, 0, 0, 0, cyc);  chk("st_cycles", cyc, 9);
    measure(5'h16, 0, 0, 0, 0, cyc);  chk("mvhi_cycles", cyc, 8);

    // Model-checked traces for every defined opcode plus one undefined
    do_reset(1);
    foreach (valid_ops[k]) run_instr(valid_ops[k], 1'b1, 1'b1, 1, 1, -1);
    run_instr(5'h07, 1'b0, 1'b0, 0, 0, -1);

    // Reset during the store write cycle, and during a held FETCH_WAIT
    run_instr(5'h05, 1'b0, 1'b0, 0, 0, 8);
    run_instr(5'h00, 1'b0, 1'b0, 2, 0, 1);

    // Random instruction stream with random waits, flags and occasional reset
    for (int t = 0; t < 400; t++) begin
      logic [4:0] op;
      int ab;
      op = ($urandom_range(0, 9) < 7) ? valid_ops[$urandom_range(0, 18)] : 5'($urandom);
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 8)) : -1;
      run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
